// File: rtl/config_frame_writer_pkg.sv
// Shared constants, header field positions and FSM state encoding for config_frame_writer.
// The CHECK state is only present when CONFIG_CRC_EN is defined.
package config_frame_pkg;

   localparam logic [31:0] SYNC_WORD  = 32'hFAB0_FAB1;
   localparam int          DESYNC_BIT = 31;
   localparam int          IDX_LSB    = 0;
   localparam int          IDX_W      = 16;

`ifdef CONFIG_CRC_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_DATA,
      ST_STROBE,
      ST_CHECK
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HEADER,
      ST_DATA,
      ST_STROBE
   } state_t;
`endif

   function automatic logic [IDX_W-1:0] header_index(input logic [31:0] word);
      return word[IDX_LSB +: IDX_W];
   endfunction

endpackage

// File: rtl/config_frame_writer_frame_strobe_decoder.sv
// Registers a frame index into a one-hot FrameStrobe pulse; indices outside the
// column are suppressed so a discarded frame never strobes any tile.
module frame_strobe_decoder
   import config_frame_pkg::*;
#(
   parameter int MaxFramesPerCol = 20
) (
   input  logic                       CLK,
   input  logic                       resetn,
   input  logic                       en,
   input  logic [IDX_W-1:0]           idx,
   output logic [MaxFramesPerCol-1:0] strobe
);

   logic                       in_range;
   logic [MaxFramesPerCol-1:0] strobe_next;

   assign in_range = idx < IDX_W'(MaxFramesPerCol);

   genvar gi;
   generate
      for (gi = 0; gi < MaxFramesPerCol; gi++) begin : g_bit
         assign strobe_next[gi] = en && in_range && (idx == IDX_W'(gi));
      end
   endgenerate

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         strobe <= '0;
      end else begin
         strobe <= strobe_next;
      end
   end

endmodule

// File: rtl/config_frame_writer.sv
// Column frame writer: SYNC-framed word stream -> FrameData assembly + one-hot FrameStrobe.
// Optional running-sum check of all data words is enabled with CONFIG_CRC_EN.
module config_frame_writer
   import config_frame_pkg::*;
#(
   parameter int MaxFramesPerCol = 20,
   parameter int FrameBitsPerRow = 32,
   parameter int NumRows         = 16
) (
   input  logic                                 CLK,
   input  logic                                 resetn,
   input  logic [31:0]                          WriteData,
   input  logic                                 WriteValid,
   output logic                                 WriteReady,
   output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
   output logic [MaxFramesPerCol-1:0]           FrameStrobe,
   output logic                                 Active,
   output logic                                 FrameError,
   output logic                                 CrcError
);

   localparam int RW = (NumRows > 1) ? $clog2(NumRows) : 1;

   state_t           state;
   logic [RW-1:0]    row_cnt;
   logic [IDX_W-1:0] frame_idx;
   logic             discard;
   logic             ready_reg;
   logic             active_reg;
   logic             frame_err_reg;

   logic             accept;
   logic             last_word;
   logic [IDX_W-1:0] hdr_idx;
   logic             hdr_in_range;

`ifdef CONFIG_CRC_EN
   logic [31:0]      crc_sum;
   logic             crc_err_reg;
`endif

   assign accept       = WriteValid && ready_reg;
   assign last_word    = accept && (state == ST_DATA) && (row_cnt == RW'(NumRows - 1));
   assign hdr_idx      = header_index(WriteData);
   assign hdr_in_range = hdr_idx < IDX_W'(MaxFramesPerCol);

   assign WriteReady = ready_reg;
   assign Active     = active_reg;
   assign FrameError = frame_err_reg;
`ifdef CONFIG_CRC_EN
   assign CrcError   = crc_err_reg;
`else
   assign CrcError   = 1'b0;
`endif

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state         <= ST_IDLE;
         row_cnt       <= '0;
         frame_idx     <= '0;
         discard       <= 1'b0;
         ready_reg     <= 1'b0;
         active_reg    <= 1'b0;
         frame_err_reg <= 1'b0;
`ifdef CONFIG_CRC_EN
         crc_sum       <= '0;
         crc_err_reg   <= 1'b0;
`endif
      end else begin
         ready_reg <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (accept && (WriteData == SYNC_WORD)) begin
                  state      <= ST_HEADER;
                  active_reg <= 1'b1;
`ifdef CONFIG_CRC_EN
                  crc_sum    <= '0;
`endif
               end
            end
            ST_HEADER: begin
               if (accept) begin
                  if (WriteData[DESYNC_BIT]) begin
                     active_reg <= 1'b0;
`ifdef CONFIG_CRC_EN
                     state      <= ST_CHECK;
`else
                     state      <= ST_IDLE;
`endif
                  end else begin
                     frame_idx <= hdr_idx;
                     row_cnt   <= '0;
                     discard   <= !hdr_in_range;
                     if (!hdr_in_range) begin
                        frame_err_reg <= 1'b1;
                     end
                     state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (accept) begin
                  row_cnt <= row_cnt + 1'b1;
`ifdef CONFIG_CRC_EN
                  crc_sum <= crc_sum + WriteData;
`endif
                  // Drop ready one cycle early so the strobe cycle never accepts a word.
                  if (last_word) begin
                     state     <= ST_STROBE;
                     ready_reg <= 1'b0;
                  end
               end
            end
            ST_STROBE: begin
               state <= ST_HEADER;
            end
`ifdef CONFIG_CRC_EN
            ST_CHECK: begin
               if (accept) begin
                  if (WriteData != crc_sum) begin
                     crc_err_reg <= 1'b1;
                  end
                  crc_sum    <= '0;
                  active_reg <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
`endif
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NumRows; gi++) begin : g_slot
         logic [FrameBitsPerRow-1:0] slot_reg;
         logic                       slot_we;

         assign slot_we = accept && (state == ST_DATA) && !discard && (row_cnt == RW'(gi));

         always_ff @(posedge CLK or negedge resetn) begin
            if (!resetn) begin
               slot_reg <= '0;
            end else if (slot_we) begin
               slot_reg <= FrameBitsPerRow'(WriteData);
            end
         end

         assign FrameData[gi*FrameBitsPerRow +: FrameBitsPerRow] = slot_reg;
      end
   endgenerate

   frame_strobe_decoder #(
      .MaxFramesPerCol(MaxFramesPerCol)
   ) u_strobe (
      .CLK    (CLK),
      .resetn (resetn),
      .en     (last_word && !discard),
      .idx    (frame_idx),
      .strobe (FrameStrobe)
   );

endmodule

// File: tb/tb_config_frame_writer.sv
// Directed bench for config_frame_writer; CRC checks are compiled in when CONFIG_CRC_EN is defined.
module tb_config_frame_writer;

   localparam int MF = 20;
   localparam int FB = 32;
   localparam int NR = 16;
   localparam int W  = NR * FB;
   localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

   logic          CLK = 1'b0;
   logic          resetn = 1'b0;
   logic [31:0]   WriteData = '0;
   logic          WriteValid = 1'b0;
   logic          WriteReady;
   logic [W-1:0]  FrameData;
   logic [MF-1:0] FrameStrobe;
   logic          Active;
   logic          FrameError;
   logic          CrcError;

   config_frame_writer #(
      .MaxFramesPerCol(MF),
      .FrameBitsPerRow(FB),
      .NumRows(NR)
   ) dut (
      .CLK         (CLK),
      .resetn      (resetn),
      .WriteData   (WriteData),
      .WriteValid  (WriteValid),
      .WriteReady  (WriteReady),
      .FrameData   (FrameData),
      .FrameStrobe (FrameStrobe),
      .Active      (Active),
      .FrameError  (FrameError),
      .CrcError    (CrcError)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int            sq_cyc[$];
   logic [MF-1:0] sq_val[$];
   always @(negedge CLK) begin
      if (FrameStrobe != '0) begin
         sq_cyc.push_back(cyc);
         sq_val.push_back(FrameStrobe);
      end
   end

   int           n_pass = 0;
   int           n_total = 0;
   int           acc_cyc = 0;
   logic [W-1:0] exp_fd = '0;
   logic [31:0]  exp_sum = '0;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
         $display("check %s: ok (%0h)", tag, obs);
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge CLK);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input bit rnd);
      int n;
      if (rnd) begin
         for (int i = 0; i < 8 && $urandom_range(0, 1) == 1; i++) begin
            WriteValid = 1'b0;
            step();
         end
      end
      WriteData  = d;
      WriteValid = 1'b1;
      n = 0;
      while (!WriteReady && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) begin
         n_total++;
         $error("FAIL send_timeout: observed ready=0 for %0d cycles expected ready=1", n);
      end
      step();
      acc_cyc    = cyc;
      WriteValid = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] idx, input logic [31:0] base,
                             input bit rnd, input bit sync_first);
      logic [31:0] w;
      send({16'h0000, idx}, rnd);
      for (int k = 0; k < NR; k++) begin
         w = (sync_first && k == 0) ? SYNC : base + 32'(k);
         send(w, rnd);
         exp_sum = exp_sum + w;
         if (idx < 16'(MF)) exp_fd[k*FB +: FB] = w;
      end
   endtask

   int n0;
   int sz;

   initial begin
      // Reset state
      step();
      step();
      check("rst_ready", W'(WriteReady), W'(1'b0));
      check("rst_strobe", W'(FrameStrobe), '0);
      check("rst_active", W'(Active), W'(1'b0));
      check("rst_ferr", W'(FrameError), W'(1'b0));
      check("rst_crc", W'(CrcError), W'(1'b0));
      check("rst_data", FrameData, '0);
      resetn = 1'b1;
      step();
      check("ready_after_rst", W'(WriteReady), W'(1'b1));

      // Frame 3 with words 0..15
      exp_sum = '0;
      send(SYNC, 1'b0);
      check("active_after_sync", W'(Active), W'(1'b1));
      send_frame(16'd3, 32'h0, 1'b0, 1'b0);
      check("strobe_f3", W'(FrameStrobe), W'(20'h0_0008));
      check("ready_in_strobe", W'(WriteReady), W'(1'b0));
      check("strobe_f3_count", W'(sq_cyc.size()), W'(1));
      check("strobe_f3_timing", W'(sq_cyc[sq_cyc.size()-1]), W'(acc_cyc));
      step();
      check("strobe_f3_off", W'(FrameStrobe), '0);
      check("fd_f3_w0", W'(FrameData[31:0]), W'(32'h0));
      check("fd_f3_w15", W'(FrameData[511:480]), W'(32'hF));
      check("fd_f3", FrameData, exp_fd);
      check("active_f3", W'(Active), W'(1'b1));

      // Back-to-back frames 0 and 19 with valid held high
      n0 = sq_cyc.size();
      send_frame(16'd0, 32'hA000_0000, 1'b0, 1'b0);
      send_frame(16'd19, 32'hB000_0000, 1'b0, 1'b0);
      check("strobe_f19", W'(FrameStrobe), W'(20'h8_0000));
      step();
      check("b2b_count", W'(sq_cyc.size()), W'(n0 + 2));
      check("b2b_first", W'(sq_val[n0]), W'(20'h0_0001));
      check("b2b_second", W'(sq_val[n0+1]), W'(20'h8_0000));
      check("b2b_spacing", W'(sq_cyc[n0+1] - sq_cyc[n0]), W'(18));
      check("fd_f19_w15", W'(FrameData[511:480]), W'(32'hB000_000F));
      check("fd_f19", FrameData, exp_fd);

      // Out-of-range index 20 is consumed but discarded
      sz = sq_cyc.size();
      send_frame(16'd20, 32'h1000_0000, 1'b0, 1'b0);
      check("strobe_discard", W'(FrameStrobe), '0);
      step();
      check("ferr_set", W'(FrameError), W'(1'b1));
      check("discard_no_strobe", W'(sq_cyc.size()), W'(sz));
      check("fd_discard_unchanged", FrameData, exp_fd);

      // Following valid frame, SYNC word appearing as ordinary data
      send_frame(16'd5, 32'hC000_0000, 1'b0, 1'b1);
      check("strobe_f5", W'(FrameStrobe), W'(20'h0_0020));
      step();
      check("fd_f5_w0_sync", W'(FrameData[31:0]), W'(32'hFAB0_FAB1));
      check("fd_f5", FrameData, exp_fd);

      // Randomly gapped valid
      send_frame(16'd7, 32'hD000_0000, 1'b1, 1'b0);
      check("strobe_f7", W'(FrameStrobe), W'(20'h0_0080));
      check("strobe_f7_timing", W'(sq_cyc[sq_cyc.size()-1]), W'(acc_cyc));
      step();
      check("fd_f7", FrameData, exp_fd);

      // Desync, then everything up to the next SYNC is ignored
      send(32'h8000_0000, 1'b0);
      check("active_desync", W'(Active), W'(1'b0));
`ifdef CONFIG_CRC_EN
      send(exp_sum, 1'b0);
      check("crc_good", W'(CrcError), W'(1'b0));
`endif
      sz = sq_cyc.size();
      send(32'h0000_0002, 1'b0);
      for (int k = 0; k < NR; k++) send(32'h5500_0000 + 32'(k), 1'b0);
      step();
      step();
      check("idle_no_strobe", W'(sq_cyc.size()), W'(sz));
      check("idle_active", W'(Active), W'(1'b0));
      check("idle_fd", FrameData, exp_fd);
      check("crc_clear_idle", W'(CrcError), W'(1'b0));

      // Reset in the middle of a frame
      exp_sum = '0;
      send(SYNC, 1'b0);
      send(32'h0000_0004, 1'b0);
      for (int k = 0; k < 8; k++) send(32'hE000_0000 + 32'(k), 1'b0);
      sz = sq_cyc.size();
      resetn = 1'b0;
      #1;
      check("midrst_strobe", W'(FrameStrobe), '0);
      check("midrst_fd", FrameData, '0);
      check("midrst_active", W'(Active), W'(1'b0));
      check("midrst_ferr", W'(FrameError), W'(1'b0));
      check("midrst_ready", W'(WriteReady), W'(1'b0));
      step();
      step();
      step();
      resetn = 1'b1;
      step();
      check("midrst_no_strobe", W'(sq_cyc.size()), W'(sz));
      exp_fd  = '0;
      exp_sum = '0;

      // Fresh session after reset
      send(SYNC, 1'b0);
      send_frame(16'd4, 32'hF000_0000, 1'b0, 1'b0);
      check("strobe_f4", W'(FrameStrobe), W'(20'h0_0010));
      step();
      check("fd_f4", FrameData, exp_fd);
      send(32'h8000_0000, 1'b0);
      check("active_desync2", W'(Active), W'(1'b0));
`ifdef CONFIG_CRC_EN
      send(exp_sum + 32'd1, 1'b0);
      check("crc_bad", W'(CrcError), W'(1'b1));
`else
      send(exp_sum + 32'd1, 1'b0);
      check("crc_tied_low", W'(CrcError), W'(1'b0));
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
